// File: rtl/lsu_split_if.sv
// Request, response and data-memory signals of the load/store unit.
// The slave modport is the LSU side; master is the pipeline plus memory.
interface lsu_split_if #(
    parameter int XLEN = 32
);
    localparam int B = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;

    logic            dmem_read;
    logic            dmem_write;
    logic [XLEN-1:0] dmem_address;
    logic [XLEN-1:0] dmem_wdata;
    logic [B-1:0]    dmem_byte_enable;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_resp;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic [4:0]      resp_rd;
    logic [XLEN-1:0] resp_addr;
    logic            resp_trap;

    modport slave (
        input  req_valid, req_store, req_funct3,
        input  req_addr, req_wdata, req_rd,
        input  dmem_rdata, dmem_resp,
        output req_ready,
        output dmem_read, dmem_write, dmem_address,
        output dmem_wdata, dmem_byte_enable,
        output resp_valid, resp_rdata, resp_rd,
        output resp_addr, resp_trap
    );

    modport master (
        output req_valid, req_store, req_funct3,
        output req_addr, req_wdata, req_rd,
        output dmem_rdata, dmem_resp,
        input  req_ready,
        input  dmem_read, dmem_write, dmem_address,
        input  dmem_wdata, dmem_byte_enable,
        input  resp_valid, resp_rdata, resp_rd,
        input  resp_addr, resp_trap
    );
endinterface

// File: rtl/lsu_split.sv
// Load/store unit: splits word-crossing accesses into two aligned
// memory transactions and merges/extends the returned load data.
module lsu_split #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    lsu_split_if.slave bus
);
    localparam int B  = XLEN / 8;
    localparam int OW = $clog2(B);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t          state_q, state_d;
    logic            store_q, trap_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, lo_q, hi_q;
    logic [4:0]      rd_q;

    logic            legal;
    logic [OW-1:0]   off;
    logic [3:0]      size;
    logic [4:0]      last;
    logic            split;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] val;
    logic [XLEN-1:0] ext;
    logic            sgn;
    int              nb;

    always_comb begin
        legal = 1'b0;
        if (bus.req_store)
            legal = (bus.req_funct3 inside {3'd0, 3'd1, 3'd2})
                 || (XLEN == 64 && bus.req_funct3 == 3'd3);
        else
            legal = (bus.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                 || (XLEN == 64 && bus.req_funct3 inside {3'd3, 3'd6});
    end

    assign off   = addr_q[OW-1:0];
    assign size  = 4'd1 << f3_q[1:0];
    assign last  = 5'(off) + 5'(size);
    assign split = last > 5'(B);
    assign base  = {addr_q[XLEN-1:OW], {OW{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid) state_d = legal ? ACC1 : RESP;
            ACC1: if (bus.dmem_resp) state_d = split ? ACC2 : RESP;
            ACC2: if (bus.dmem_resp) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q <= 1'b0;
            trap_q  <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    store_q <= bus.req_store;
                    trap_q  <= !legal;
                    f3_q    <= bus.req_funct3;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    rd_q    <= bus.req_rd;
                    lo_q    <= '0;
                    hi_q    <= '0;
                end
                ACC1: if (bus.dmem_resp) lo_q <= bus.dmem_rdata;
                ACC2: if (bus.dmem_resp) hi_q <= bus.dmem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready        = (state_q == IDLE);
        bus.dmem_read        = 1'b0;
        bus.dmem_write       = 1'b0;
        bus.dmem_address     = '0;
        bus.dmem_wdata       = '0;
        bus.dmem_byte_enable = '0;
        case (state_q)
            ACC1: begin
                bus.dmem_read    = !store_q;
                bus.dmem_write   = store_q;
                bus.dmem_address = base;
                bus.dmem_wdata   = wdata_q << (8 * int'(off));
                for (int i = 0; i < B; i++)
                    bus.dmem_byte_enable[i] =
                        (5'(i) >= 5'(off)) && (5'(i) < last);
            end
            ACC2: begin
                bus.dmem_read    = !store_q;
                bus.dmem_write   = store_q;
                bus.dmem_address = base + XLEN'(B);
                bus.dmem_wdata   = wdata_q >> (8 * (B - int'(off)));
                for (int i = 0; i < B; i++)
                    bus.dmem_byte_enable[i] = 5'(i) < (last - 5'(B));
            end
            default: ;
        endcase
    end

    // Bring byte o of {hi,lo} down to lane 0, then extend S bytes
    assign val = XLEN'({hi_q, lo_q} >> (8 * int'(off)));
    assign nb  = 8 * int'(size);

    always_comb begin
        case (f3_q[1:0])
            2'b00:   sgn = val[7];
            2'b01:   sgn = val[15];
            2'b10:   sgn = val[31];
            default: sgn = val[XLEN-1];
        endcase
        sgn = sgn && !f3_q[2];
        ext = '0;
        for (int i = 0; i < XLEN; i++)
            ext[i] = (i < nb) ? val[i] : sgn;
    end

    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = (store_q || trap_q) ? '0 : ext;
    assign bus.resp_rd    = rd_q;
    assign bus.resp_addr  = addr_q;
    assign bus.resp_trap  = trap_q;
endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split: aligned/split loads and stores, traps,
// wait states, address wrap and reset in the middle of an access.
module tb_lsu_split;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_split_if #(.XLEN(32)) bus ();

    lsu_split #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int          cyc;
    int          nacc;
    logic [31:0] a   [2];
    logic [3:0]  be  [2];
    logic [31:0] wd  [2];
    logic [31:0] res;
    logic        trp;
    logic [4:0]  rrd;
    logic [31:0] raddr;
    logic        rd_seen, wr_seen, both_seen;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic run(input logic st, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] wdat,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input int wt);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = ad;
        bus.req_wdata  = wdat;
        bus.req_rd     = 5'd7;
        nacc = 0;
        cyc  = -1;
        rd_seen = 1'b0;
        wr_seen = 1'b0;
        both_seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a[k] = '0; be[k] = '0; wd[k] = '0;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int c = 1; c < 40 && cyc < 0; c++) begin
            if (bus.resp_valid) begin
                cyc   = c;
                res   = bus.resp_rdata;
                trp   = bus.resp_trap;
                rrd   = bus.resp_rd;
                raddr = bus.resp_addr;
                bus.dmem_resp = 1'b0;
            end else if (bus.dmem_read || bus.dmem_write) begin
                if (nacc < 2) begin
                    a[nacc]  = bus.dmem_address;
                    be[nacc] = bus.dmem_byte_enable;
                    wd[nacc] = bus.dmem_wdata;
                end
                rd_seen   |= bus.dmem_read;
                wr_seen   |= bus.dmem_write;
                both_seen |= bus.dmem_read && bus.dmem_write;
                if (waited < wt) begin
                    waited++;
                    bus.dmem_resp = 1'b0;
                end else begin
                    bus.dmem_resp  = 1'b1;
                    bus.dmem_rdata = (nacc == 0) ? rd1 : rd2;
                    nacc++;
                    waited = 0;
                end
            end else begin
                bus.dmem_resp = 1'b0;
            end
            if (cyc < 0) @(negedge clk);
        end
    endtask

    logic seen;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rd     = '0;
        bus.dmem_rdata = '0;
        bus.dmem_resp  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", bus.req_ready, 1);
        check("rst_read", bus.dmem_read, 0);
        check("rst_write", bus.dmem_write, 0);
        check("rst_be", bus.dmem_byte_enable, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);

        // lw aligned
        run(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0);
        check("lw_addr", a[0], 32'h100);
        check("lw_be", be[0], 4'b1111);
        check("lw_data", res, 32'hDEADBEEF);
        check("lw_cyc", cyc, 2);
        check("lw_nacc", nacc, 1);
        check("lw_strobe", {both_seen, wr_seen, rd_seen}, 3'b001);
        check("lw_rd", rrd, 5'd7);
        check("lw_raddr", raddr, 32'h100);

        // lh split
        run(0, 3'b001, 32'h103, 0, 32'hAABBCCDD, 32'h112233F4, 0);
        check("lh_a1", a[0], 32'h100);
        check("lh_be1", be[0], 4'b1000);
        check("lh_a2", a[1], 32'h104);
        check("lh_be2", be[1], 4'b0001);
        check("lh_data", res, 32'hFFFFF4AA);
        check("lh_cyc", cyc, 3);
        run(0, 3'b101, 32'h103, 0, 32'hAABBCCDD, 32'h112233F4, 0);
        check("lhu_data", res, 32'h0000F4AA);

        // sw split
        run(1, 3'b010, 32'h6, 32'h12345678, 0, 0, 0);
        check("sw_a1", a[0], 32'h4);
        check("sw_be1", be[0], 4'b1100);
        check("sw_wd1", wd[0], 32'h56780000);
        check("sw_a2", a[1], 32'h8);
        check("sw_be2", be[1], 4'b0011);
        check("sw_wd2", wd[1], 32'h00001234);
        check("sw_data", res, 0);
        check("sw_cyc", cyc, 3);
        check("sw_strobe", {both_seen, wr_seen, rd_seen}, 3'b010);

        // byte loads, the second with three wait cycles
        run(0, 3'b000, 32'h102, 0, 32'h00800000, 0, 0);
        check("lb_be", be[0], 4'b0100);
        check("lb_data", res, 32'hFFFFFF80);
        run(0, 3'b100, 32'h102, 0, 32'h00800000, 0, 3);
        check("lbu_data", res, 32'h00000080);
        check("lbu_wait_cyc", cyc, 5);

        // illegal funct3
        run(0, 3'b011, 32'h40, 0, 32'h1, 32'h2, 0);
        check("trap_flag", trp, 1);
        check("trap_cyc", cyc, 1);
        check("trap_nacc", nacc, 0);
        check("trap_data", res, 0);
        run(1, 3'b100, 32'h40, 32'hFF, 0, 0, 0);
        check("strap_flag", trp, 1);
        check("strap_nacc", nacc, 0);

        // wrap-around split
        run(0, 3'b010, 32'hFFFFFFFE, 0, 32'h55667788, 32'h99AABBCC, 0);
        check("wrap_a1", a[0], 32'hFFFFFFFC);
        check("wrap_be1", be[0], 4'b1100);
        check("wrap_a2", a[1], 32'h0);
        check("wrap_be2", be[1], 4'b0011);
        check("wrap_data", res, 32'hBBCC5566);
        check("wrap_trap", trp, 0);

        // reset while waiting in the second access
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h1FE;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h01020304;
        @(negedge clk);
        bus.dmem_resp = 1'b0;
        check("mid_acc2_read", bus.dmem_read, 1);
        check("mid_acc2_addr", bus.dmem_address, 32'h200);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_read", bus.dmem_read, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        check("mid_no_resp", seen, 0);
        run(0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 0, 0);
        check("post_rst_data", res, 32'hCAFEF00D);
        check("post_rst_cyc", cyc, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
